ads127l01_seq: RTL and testbench

Acquisition sequencer for the ADS127L01 capture path. It drives the ADC control pins (reset_n, start, osr, filter, hr) and the capture enable of the serial-receive/AXIS block. It runs the power-up reset/settle sequence, then a gated acquisition run of N AXIS blocks, or a continuous run. A fsync watchdog detects a stalled converter. It sits between the register/command logic and the ADS127L01 capture block, on the same system clock.

---
 rtl/ads127l01_seq.sv | 158 +++++++++++++++
 tb/tb_ads127l01_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ads127l01_seq.sv
// ADS127L01 acquisition sequencer: power-up reset/settle, gated or continuous
// capture run, and an fsync watchdog that latches a fault on a stalled converter.
module ads127l01_seq #(
    parameter int unsigned RST_CYC    = 64,
    parameter int unsigned SETTLE_CYC = 4096,
    parameter int unsigned WD_CYC     = 65536,
    parameter int unsigned BW         = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_go,
    input  logic          cmd_stop,
    input  logic [1:0]    cfg_osr,
    input  logic [1:0]    cfg_filter,
    input  logic          cfg_hr,
    input  logic [BW-1:0] cfg_nblk,
    input  logic          fsync,
    input  logic          blk_last,
    output logic          adc_reset_n,
    output logic          adc_start,
    output logic [1:0]    adc_osr,
    output logic [1:0]    adc_filter,
    output logic          adc_hr,
    output logic          cap_en,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [BW-1:0] blk_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SETTLE, S_RUN, S_DRAIN, S_FAULT
    } state_t;

    state_t        state, state_d;
    logic [31:0]   cnt, cnt_d;
    logic [BW-1:0] nblk_q;
    logic          fsync_p0, fsync_p1, fsync_p2;
    logic          fsync_rise;
    logic          go_acc, final_blk;
    logic          reset_n_d, run_d, busy_d, done_d, fault_d;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign go_acc     = cmd_go && (state == S_IDLE || state == S_FAULT);
    assign fsync_rise = fsync_p1 && !fsync_p2;
    assign final_blk  = blk_last && (nblk_q != '0) && (sat_inc(blk_cnt) == nblk_q);

    // fsync stage p0/p1: two-flop synchronizer; p2: edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsync_p0 <= 1'b0;
            fsync_p1 <= 1'b0;
            fsync_p2 <= 1'b0;
        end else begin
            fsync_p0 <= fsync;
            fsync_p1 <= fsync_p0;
            fsync_p2 <= fsync_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_osr    <= '0;
            adc_filter <= '0;
            adc_hr     <= 1'b0;
            nblk_q     <= '0;
            blk_cnt    <= '0;
        end else if (go_acc) begin
            adc_osr    <= cfg_osr;
            adc_filter <= cfg_filter;
            adc_hr     <= cfg_hr;
            nblk_q     <= cfg_nblk;
            blk_cnt    <= '0;
        end else if (state == S_RUN && blk_last) begin
            blk_cnt    <= sat_inc(blk_cnt);
        end
    end

    // State register; pin outputs are registered from the next state so they are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            adc_reset_n <= 1'b0;
            adc_start   <= 1'b0;
            cap_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            adc_reset_n <= reset_n_d;
            adc_start   <= run_d;
            cap_en      <= run_d;
            busy        <= busy_d;
            done        <= done_d;
            fault       <= fault_d;
        end
    end

    // cnt times RST and SETTLE, and serves as the fsync watchdog in RUN
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 32'd1;
        case (state)
            S_IDLE, S_FAULT: begin
                cnt_d = '0;
                if (cmd_go) state_d = S_RST;
            end
            S_RST: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (cnt == RST_CYC - 1) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (cnt == SETTLE_CYC - 1) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (fsync_rise) cnt_d = '0;
                // final block wins over both stop and watchdog expiry
                if (final_blk || cmd_stop)
                    state_d = S_DRAIN;
                else if (!fsync_rise && cnt == WD_CYC - 1)
                    state_d = S_FAULT;
            end
            S_DRAIN: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        reset_n_d = (state_d != S_RST);
        run_d     = (state_d == S_RUN);
        busy_d    = (state_d == S_RST) || (state_d == S_SETTLE) ||
                    (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d    = (state == S_DRAIN) && (state_d == S_IDLE);
        fault_d   = (state_d == S_FAULT);
    end

endmodule

// File: tb/tb_ads127l01_seq.sv
// Self-checking bench for ads127l01_seq: sequencing, block counting via a
// scoreboard queue, watchdog fault, stop handling and asynchronous reset.
module tb_ads127l01_seq;

    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_go = 1'b0, cmd_stop = 1'b0;
    logic [1:0]    cfg_osr = '0, cfg_filter = '0;
    logic          cfg_hr = 1'b0;
    logic [BW-1:0] cfg_nblk = '0;
    logic          fsync;
    logic          blk_last = 1'b0;
    logic          adc_reset_n, adc_start, adc_hr, cap_en, busy, done, fault;
    logic [1:0]    adc_osr, adc_filter;
    logic [BW-1:0] blk_cnt;

    ads127l01_seq #(.RST_CYC(8), .SETTLE_CYC(16), .WD_CYC(200), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_go(cmd_go), .cmd_stop(cmd_stop),
        .cfg_osr(cfg_osr), .cfg_filter(cfg_filter), .cfg_hr(cfg_hr),
        .cfg_nblk(cfg_nblk), .fsync(fsync), .blk_last(blk_last),
        .adc_reset_n(adc_reset_n), .adc_start(adc_start), .adc_osr(adc_osr),
        .adc_filter(adc_filter), .adc_hr(adc_hr), .cap_en(cap_en),
        .busy(busy), .done(done), .fault(fault), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int            n_chk = 0, n_err = 0;
    int            done_seen = 0;
    logic [BW-1:0] exp_cnt = '0;
    logic [BW-1:0] exp_q[$];
    logic          blk_seen = 1'b0;
    logic          fs_en = 1'b0, fs_tog = 1'b0;

    assign fsync = fs_en & fs_tog;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_go(input logic [1:0] osr, input logic [1:0] filt, input logic hr,
                            input logic [BW-1:0] nblk, input logic accepted);
        cfg_osr = osr; cfg_filter = filt; cfg_hr = hr; cfg_nblk = nblk;
        cmd_go = 1'b1;
        if (accepted) exp_cnt = '0;
        tick(1);
        cmd_go = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
    endtask

    task automatic blk(input int gap);
        blk_last = 1'b1;
        exp_cnt  = (&exp_cnt) ? exp_cnt : exp_cnt + 1'b1;
        exp_q.push_back(exp_cnt);
        tick(1);
        blk_last = 1'b0;
        tick(gap);
    endtask

    task automatic wait_run();
        int n = 0;
        while (!cap_en && n < 500) begin
            n++;
            tick(1);
        end
        chk("run_entry", cap_en, 1);
    endtask

    // fsync source: rising edge every 100 cycles when enabled
    initial forever begin
        tick(50);
        fs_tog = ~fs_tog;
    end

    // Scoreboard: each accepted blk_last is compared one edge later
    always @(posedge clk) blk_seen <= blk_last & rst_n;
    always @(negedge clk) begin
        if (blk_seen && exp_q.size() > 0) chk("blk_cnt", blk_cnt, exp_q.pop_front());
        if (done) done_seen++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        tick(3);
        chk("reset_outs", {adc_reset_n, adc_start, adc_osr, adc_filter, adc_hr, cap_en,
                           busy, done, fault, blk_cnt}, 0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_reset_n", adc_reset_n, 1);
        chk("idle_busy", busy, 0);

        // power-up sequence timing and latched pins
        fs_en = 1'b1;
        pulse_go(2'd2, 2'd1, 1'b1, 16'd3, 1'b1);
        chk("rst_pins", {adc_osr, adc_filter, adc_hr}, 5'b10_01_1);
        chk("rst_busy", busy, 1);
        n = 0;
        while (!adc_reset_n && n < 100) begin n++; tick(1); end
        chk("rst_low_cycles", n, 8);
        n = 0;
        while (!adc_start && n < 100) begin n++; tick(1); end
        chk("settle_cycles", n, 16);
        chk("run_cap_en", cap_en, 1);
        chk("run_pins", {adc_osr, adc_filter, adc_hr}, 5'b10_01_1);

        // gated run of 3 blocks
        blk(30);
        blk(30);
        blk(0);
        chk("drain_cap_en", cap_en, 0);
        chk("drain_start", adc_start, 0);
        chk("drain_done", done, 0);
        tick(1);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        tick(1);
        chk("done_single", done, 0);
        chk("final_cnt", blk_cnt, 3);

        // continuous run stopped by command
        pulse_go(2'd1, 2'd2, 1'b0, 16'd0, 1'b1);
        wait_run();
        for (int i = 0; i < 10; i++) blk(10);
        tick(20);
        chk("cont_running", cap_en, 1);
        pulse_stop();
        chk("stop_cap_en", cap_en, 0);
        tick(1);
        chk("stop_done", done, 1);
        chk("stop_cnt", blk_cnt, 10);
        chk("stop_fault", fault, 0);

        // watchdog: fsync held low through RUN
        fs_en = 1'b0;
        tick(5);
        pulse_go(2'd3, 2'd3, 1'b1, 16'd5, 1'b1);
        wait_run();
        n = 0;
        while (!fault && n < 1000) begin n++; tick(1); end
        chk("wd_cycles", n, 200);
        chk("wd_outs", {adc_start, cap_en, busy, adc_reset_n}, 4'b0001);
        tick(10);
        chk("wd_sticky", fault, 1);
        pulse_go(2'd3, 2'd3, 1'b1, 16'd5, 1'b1);
        chk("wd_clear", fault, 0);
        chk("wd_restart_rst", adc_reset_n, 0);

        // stop during SETTLE
        n = 0;
        while (!adc_reset_n && n < 100) begin n++; tick(1); end
        tick(3);
        pulse_stop();
        chk("settle_stop_busy", busy, 0);
        chk("settle_stop_rn", adc_reset_n, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (adc_start || done) n++;
            tick(1);
        end
        chk("settle_stop_quiet", n, 0);

        // cmd_go ignored in RUN
        fs_en = 1'b1;
        pulse_go(2'd0, 2'd2, 1'b0, 16'd4, 1'b1);
        wait_run();
        pulse_go(2'd1, 2'd1, 1'b1, 16'd1, 1'b0);
        chk("go_ignored_pins", {adc_osr, adc_filter, adc_hr}, 5'b00_10_0);
        chk("go_ignored_run", {adc_reset_n, cap_en}, 2'b11);
        blk(2);

        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("async_reset", {adc_reset_n, adc_start, adc_osr, adc_filter, adc_hr, cap_en,
                            busy, done, fault, blk_cnt}, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_reset_rn", adc_reset_n, 1);
        chk("post_reset_cnt", blk_cnt, 0);
        chk("post_reset_busy", busy, 0);
        chk("done_total", done_seen, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
